// File: rtl/keypad_scan_encoder.sv
// Scans a 4x3 active-low matrix keypad. Each debounced press produces one
// key code, held for a single clock cycle. At all other times the idle code
// 4'b1111 is driven.
module keypad_scan_encoder #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DebLimit = CntW'(DEBOUNCE_CNT);
    localparam logic [CntW-1:0] CntSat   = CntW'(CntMax);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StEmit,
        StWaitRelease
    } state_e;

    state_e          state_q;
    logic [1:0]      row_q;
    logic [1:0]      col_idx_q;
    logic [2:0]      col_pat_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      col_meta_q;
    logic [2:0]      col_sync_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;

    logic [CntW-1:0] cnt_inc;
    logic            one_low;
    logic [1:0]      one_low_idx;

    // Key map: rows 0..2 encode as row*3+col+1; the bottom row holds '*', '0' and '#'.
    function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r == 2'd3) begin
            unique case (c)
                2'd0:    code = 4'b1101;
                2'd1:    code = 4'b1010;
                default: code = 4'b1110;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

    // Saturating increment and detection of exactly one low column.
    always_comb begin
        cnt_inc     = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
        one_low     = 1'b1;
        one_low_idx = 2'd0;
        unique case (col_sync_q)
            3'b110:  one_low_idx = 2'd0;
            3'b101:  one_low_idx = 2'd1;
            3'b011:  one_low_idx = 2'd2;
            default: one_low = 1'b0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Scan / debounce / emit / release FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StScan;
            row_q       <= 2'd0;
            col_idx_q   <= 2'd0;
            col_pat_q   <= 3'b111;
            cnt_q       <= '0;
            key_code_q  <= 4'b1111;
            key_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StScan: begin
                    if (cnt_q >= ScanLast) begin
                        cnt_q <= '0;
                        if (one_low) begin
                            col_pat_q <= col_sync_q;
                            col_idx_q <= one_low_idx;
                            state_q   <= StDebounce;
                        end else begin
                            // No key or a ghosting multi-key pattern: move on.
                            row_q <= row_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDebounce: begin
                    if (col_sync_q == col_pat_q) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc >= DebLimit) begin
                            state_q     <= StEmit;
                            key_code_q  <= encode(row_q, col_idx_q);
                            key_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= '0;
                        row_q   <= row_q + 2'd1;
                        state_q <= StScan;
                    end
                end
                StEmit: begin
                    key_code_q  <= 4'b1111;
                    key_valid_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= StWaitRelease;
                end
                StWaitRelease: begin
                    if (col_sync_q == 3'b111) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc >= DebLimit) begin
                            cnt_q   <= '0;
                            row_q   <= 2'd0;
                            state_q <= StScan;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= StScan;
                    cnt_q   <= '0;
                    row_q   <= 2'd0;
                end
            endcase
        end
    end

    assign row_n     = ~(4'b0001 << row_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule
